// File: rtl/ff_step_controller.sv
// Step sequencer for the flip-flop exerciser: synchronizes and debounces the step
// button, optionally free-runs auto steps, and routes each step as a one-cycle clock enable.
module ff_step_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int AUTO_DIV        = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       auto_en,
    input  logic [1:0] target_sel,
    output logic       ce_d,
    output logic       ce_jk,
    output logic       ce_t,
    output logic [7:0] step_count,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PRE_W = $clog2(AUTO_DIV);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_e;

    typedef enum logic [1:0] {
        RR_D  = 2'd0,
        RR_JK = 2'd1,
        RR_T  = 2'd2
    } rr_e;

    logic             btn_meta_q, btn_meta_d;
    logic             btn_sync_q, btn_sync_d;
    logic             btn_s;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_step_q, btn_step_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             auto_wrap_q, auto_wrap_d;
    logic             auto_step_q, auto_step_d;
    rr_e              rr_q, rr_d;
    rr_e              dest_s;
    logic             step_s;
    logic             ce_d_q, ce_d_d;
    logic             ce_jk_q, ce_jk_d;
    logic             ce_t_q, ce_t_d;
    logic [7:0]       count_q, count_d;

    function automatic rr_e rr_advance(input rr_e cur);
        rr_e nxt;
        case (cur)
            RR_D:    nxt = RR_JK;
            RR_JK:   nxt = RR_T;
            RR_T:    nxt = RR_D;
            default: nxt = RR_D;
        endcase
        return nxt;
    endfunction

    // Two-stage synchronizer for the asynchronous button input.
    always_comb begin
        btn_meta_d = btn_raw;
        btn_sync_d = btn_meta_q;
    end

    assign btn_s = btn_sync_q;

    // Debounce FSM: a level must stay stable for DEBOUNCE_CYCLES samples to be accepted.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        btn_step_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_HELD;
                    cnt_d      = CNT_ZERO;
                    btn_step_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_HELD;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Auto prescaler; the wrap pulse is retimed one cycle before it becomes a step.
    always_comb begin
        presc_d     = presc_q;
        auto_wrap_d = 1'b0;
        auto_step_d = auto_wrap_q;
        if (!auto_en) begin
            presc_d     = PRE_ZERO;
            auto_wrap_d = 1'b0;
        end else if (presc_q == PRE_LAST) begin
            presc_d     = PRE_ZERO;
            auto_wrap_d = 1'b1;
        end else begin
            presc_d     = presc_q + PRE_ONE;
            auto_wrap_d = 1'b0;
        end
    end

    // Step routing, round-robin pointer and step counter.
    always_comb begin
        step_s  = btn_step_q | auto_step_q;
        rr_d    = rr_q;
        count_d = count_q;
        ce_d_d  = 1'b0;
        ce_jk_d = 1'b0;
        ce_t_d  = 1'b0;
        case (target_sel)
            2'b00:   dest_s = RR_D;
            2'b01:   dest_s = RR_JK;
            2'b10:   dest_s = RR_T;
            2'b11:   dest_s = rr_q;
            default: dest_s = RR_D;
        endcase
        if (step_s) begin
            count_d = count_q + 8'd1;
            if (target_sel == 2'b11) begin
                rr_d = rr_advance(rr_q);
            end else begin
                rr_d = rr_q;
            end
            case (dest_s)
                RR_D:    ce_d_d  = 1'b1;
                RR_JK:   ce_jk_d = 1'b1;
                RR_T:    ce_t_d  = 1'b1;
                default: ce_d_d  = 1'b0;
            endcase
        end else begin
            count_d = count_q;
            rr_d    = rr_q;
        end
    end

    // State register; reset aborts any debounce or prescale count in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            btn_step_q  <= 1'b0;
            presc_q     <= PRE_ZERO;
            auto_wrap_q <= 1'b0;
            auto_step_q <= 1'b0;
            rr_q        <= RR_D;
            ce_d_q      <= 1'b0;
            ce_jk_q     <= 1'b0;
            ce_t_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            btn_meta_q  <= btn_meta_d;
            btn_sync_q  <= btn_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_step_q  <= btn_step_d;
            presc_q     <= presc_d;
            auto_wrap_q <= auto_wrap_d;
            auto_step_q <= auto_step_d;
            rr_q        <= rr_d;
            ce_d_q      <= ce_d_d;
            ce_jk_q     <= ce_jk_d;
            ce_t_q      <= ce_t_d;
            count_q     <= count_d;
        end
    end

    assign ce_d       = ce_d_q;
    assign ce_jk      = ce_jk_q;
    assign ce_t       = ce_t_q;
    assign step_count = count_q;
    assign dbg_state  = state_q;

    ff_step_controller_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .ce_d       (ce_d_q),
        .ce_jk      (ce_jk_q),
        .ce_t       (ce_t_q),
        .step_count (count_q)
    );

endmodule

// Runtime properties of the step outputs: enables are mutually exclusive and
// every enable pulse is accompanied by exactly one counter increment.
module ff_step_controller_chk (
    input logic       clk,
    input logic       reset,
    input logic       ce_d,
    input logic       ce_jk,
    input logic       ce_t,
    input logic [7:0] step_count
);

    a_ce_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0({ce_d, ce_jk, ce_t}));

    a_count_step: assert property (@(posedge clk) disable iff (reset)
        (ce_d | ce_jk | ce_t) |-> (step_count == ($past(step_count) + 8'd1)));

endmodule

// File: tb/tb_ff_step_controller.sv
// Directed bench for ff_step_controller with DEBOUNCE_CYCLES=4 and AUTO_DIV=8:
// a vector table for reset/bounce/clean-press plus sequences for multi-cycle cases.
module tb_ff_step_controller;

    localparam int DEB  = 4;
    localparam int ADIV = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic       auto_en;
    logic [1:0] target_sel;
    logic       ce_d, ce_jk, ce_t;
    logic [7:0] step_count;
    logic [1:0] dbg_state;
    logic [2:0] ce_v;

    assign ce_v = {ce_d, ce_jk, ce_t};

    ff_step_controller #(.DEBOUNCE_CYCLES(DEB), .AUTO_DIV(ADIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .auto_en    (auto_en),
        .target_sel (target_sel),
        .ce_d       (ce_d),
        .ce_jk      (ce_jk),
        .ce_t       (ce_t),
        .step_count (step_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       btn;
        logic       aen;
        logic [1:0] sel;
        logic [2:0] ce;
        logic [7:0] cnt;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   multi_ce = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if ($countones(ce_v) > 1) multi_ce++;
    endtask

    task automatic add(input int n, input logic rst, input logic btn, input logic aen,
                       input logic [1:0] sel, input logic [2:0] ce, input logic [7:0] cnt,
                       input logic [1:0] st);
        vec_t v;
        v.rst = rst; v.btn = btn; v.aen = aen; v.sel = sel;
        v.ce = ce; v.cnt = cnt; v.st = st;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        btn_raw = 1'b0;
        auto_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic press_release(input int hold, output logic [2:0] seen, output int pulses);
        seen   = 3'b000;
        pulses = 0;
        btn_raw = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (ce_v != 3'b000) begin pulses++; seen |= ce_v; end
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ce_v != 3'b000) begin pulses++; seen |= ce_v; end
        end
    endtask

    initial begin
        logic [2:0] seen;
        logic [2:0] rr_exp [4];
        int pulses, first, last, bad_int, other_ce, wrap_ok, at;

        reset = 1'b1; btn_raw = 1'b0; auto_en = 1'b0; target_sel = 2'b00;

        // reset, then idle after release
        add(3, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 8'd0, 2'd0);
        add(2, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'd0, 2'd0);
        // bounce 1,1,0,1,1,0 then low: FSM lags the input by two sync stages
        add(1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 8'd0, 2'd0);
        add(1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 8'd0, 2'd0);
        add(1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'd0, 2'd1);
        add(1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 8'd0, 2'd1);
        add(1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 8'd0, 2'd0);
        add(1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'd0, 2'd1);
        add(1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'd0, 2'd1);
        add(9, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'd0, 2'd0);
        // clean press to D: 20 cycles held, pulse at the 7th edge after btn rises
        add(2,  1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 8'd0, 2'd0);
        add(3,  1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 8'd0, 2'd1);
        add(1,  1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 8'd0, 2'd2);
        add(1,  1'b0, 1'b1, 1'b0, 2'b00, 3'b100, 8'd1, 2'd2);
        add(13, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 8'd1, 2'd2);
        add(2,  1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'd1, 2'd2);
        add(3,  1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'd1, 2'd3);
        add(3,  1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'd1, 2'd0);

        foreach (vecs[k]) begin
            reset      = vecs[k].rst;
            btn_raw    = vecs[k].btn;
            auto_en    = vecs[k].aen;
            target_sel = vecs[k].sel;
            tick();
            check($sformatf("vec%0d_ce", k),    ce_v,       vecs[k].ce);
            check($sformatf("vec%0d_count", k), step_count, vecs[k].cnt);
            check($sformatf("vec%0d_state", k), dbg_state,  vecs[k].st);
        end

        // round-robin D -> JK -> T -> D
        rr_exp = '{3'b100, 3'b010, 3'b001, 3'b100};
        do_reset();
        target_sel = 2'b11;
        for (int p = 0; p < 4; p++) begin
            press_release(10, seen, pulses);
            check($sformatf("rr%0d_ce", p), seen, rr_exp[p]);
            check($sformatf("rr%0d_pulses", p), pulses, 1);
        end
        check("rr_count", step_count, 8'd4);

        // auto mode on T for 8x260 cycles, counter wraps through 0
        do_reset();
        target_sel = 2'b10;
        auto_en = 1'b1;
        pulses = 0; first = 0; last = 0; bad_int = 0; other_ce = 0; wrap_ok = 0;
        for (int i = 1; i <= 2100; i++) begin
            if (i == 2081) auto_en = 1'b0;
            tick();
            if (ce_v != 3'b000) begin
                pulses++;
                if (ce_v != 3'b001) other_ce++;
                if (pulses == 1) first = i;
                else if (i - last != ADIV) bad_int++;
                last = i;
                if (pulses == 255 && step_count == 8'd255) wrap_ok++;
                if (pulses == 256 && step_count == 8'd0) wrap_ok++;
            end
        end
        check("auto_first_latency", first, ADIV + 2);
        check("auto_interval_errs", bad_int, 0);
        check("auto_pulses", pulses, 260);
        check("auto_wrong_target", other_ce, 0);
        check("auto_wrap_255_0", wrap_ok, 2);
        check("auto_final_count", step_count, 8'd4);

        // auto_en dropped exactly at the wrap edge suppresses the step
        do_reset();
        target_sel = 2'b10;
        auto_en = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == ADIV) auto_en = 1'b0;
            tick();
            if (ce_v != 3'b000) pulses++;
        end
        check("auto_suppress_pulses", pulses, 0);
        auto_en = 1'b1;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ce_v != 3'b000 && first == 0) first = i;
        end
        auto_en = 1'b0;
        check("auto_restart_latency", first, ADIV + 2);
        check("auto_restart_count", step_count, 8'd1);

        // button step aligned with auto step: one pulse, one increment
        do_reset();
        target_sel = 2'b00;
        auto_en = 1'b1;
        pulses = 0; at = 0; seen = 3'b000;
        for (int i = 1; i <= 16; i++) begin
            if (i == 4) btn_raw = 1'b1;
            tick();
            if (ce_v != 3'b000) begin pulses++; at = i; seen |= ce_v; end
        end
        check("coinc_pulses", pulses, 1);
        check("coinc_cycle", at, 10);
        check("coinc_ce", seen, 3'b100);
        check("coinc_count", step_count, 8'd1);
        auto_en = 1'b0;
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // reset in PRESS_WAIT (count 3) with button still held
        do_reset();
        target_sel = 2'b01;
        btn_raw = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("mid_pw_state", dbg_state, 2'd1);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("mid_rst%0d_state", i), dbg_state, 2'd0);
            check($sformatf("mid_rst%0d_ce", i), ce_v, 3'b000);
        end
        reset = 1'b0;
        pulses = 0; at = 0; seen = 3'b000;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (ce_v != 3'b000) begin pulses++; at = j; seen |= ce_v; end
        end
        check("mid_post_pulses", pulses, 1);
        check("mid_post_cycle", at, DEB + 3);
        check("mid_post_ce", seen, 3'b010);
        check("mid_post_count", step_count, 8'd1);
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        check("ce_onehot_violations", multi_ce, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ff_step_controller.md
# ff_step_controller

Step sequencer for the flip-flop exerciser datapath (D, JK and T flip-flops). It replaces raw push-button clocking with a clean system-clock design. The controller synchronizes and debounces the step button and optionally generates free-running auto steps. It issues each step as a single-cycle clock-enable to one selected flip-flop, or to each flip-flop in turn, and counts the steps it has issued.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized samples needed to accept a press or a release (10 ms at 100 MHz); must be ≥ 2.
- AUTO_DIV, 50_000_000: auto-step period in clk cycles; must be ≥ 2.

Ports:
- clk  in  1  system clock, 100 MHz; all logic on the rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- btn_raw  in  1  step push-button; asynchronous and bouncing.
- auto_en  in  1  1 = free-run auto stepping.
- target_sel  in  2  step destination:
  - 00 = D.
  - 01 = JK.
  - 10 = T.
  - 11 = round-robin D→JK→T.
- ce_d  out  1  one-cycle clock-enable to the D flip-flop.
- ce_jk  out  1  one-cycle clock-enable to the JK flip-flop.
- ce_t  out  1  one-cycle clock-enable to the T flip-flop.
- step_count  out  8  number of steps issued, modulo 256.
- dbg_state  out  2  debounce FSM state for LEDs:
  - 0 = IDLE.
  - 1 = PRESS_WAIT.
  - 2 = HELD.
  - 3 = RELEASE_WAIT.

## Operation
Input synchronizer:
- btn_raw passes through a 2-flop synchronizer; only its output (btn_s) is used.

Debounce FSM (stable-count counter, width ceil(log2(DEBOUNCE_CYCLES+1))):
- IDLE: btn_s=1 → PRESS_WAIT, count=1.
- PRESS_WAIT:
  - btn_s=0 → IDLE, count=0. A bounce produces no step.
  - btn_s=1 and count = DEBOUNCE_CYCLES−1 → HELD; raise internal btn_step for one cycle.
  - Otherwise count+1.
- HELD: btn_s=0 → RELEASE_WAIT, count=1.
- RELEASE_WAIT:
  - btn_s=1 → HELD, count=0. No step.
  - btn_s=0 and count = DEBOUNCE_CYCLES−1 → IDLE.
  - Otherwise count+1.
- Exactly one step per accepted press, regardless of how long the button is held.

Auto stepper:
- Prescaler counts 0..AUTO_DIV−1 while auto_en=1.
- At AUTO_DIV−1 it wraps to 0 and raises auto_step for one cycle.
- auto_en=0 holds the prescaler at 0.

Step issue:
- step = btn_step OR auto_step. Coincident events produce a single step.
- Routing uses target_sel as sampled in the step cycle.
- Round-robin pointer:
  - Starts at D.
  - Advances D→JK→T→D only on steps issued with target_sel=11.
  - Holds otherwise; changing target_sel does not reset it.
- step_count increments by 1 on every issued step and wraps 255→0.
- At most one ce_* is high in any cycle.

Reset values:
- ce_d=ce_jk=ce_t=0, step_count=0, dbg_state=IDLE.
- Synchronizer flops, debounce count and prescaler = 0; round-robin pointer = D.

## Timing
- ce_* outputs are registered: a ce pulse is high for exactly one cycle, the cycle after the internal step event.
- Button latency:
  - btn_raw goes high and stays clean before edge E.
  - The ce pulse is high from edge E+DEBOUNCE_CYCLES+2 until the next edge.
  - step_count updates at the same edge as the ce pulse.
- Auto latency:
  - auto_en goes high before edge E.
  - The first ce pulse rises at edge E+AUTO_DIV+1, then every AUTO_DIV cycles.
- A button step and an auto step in the same cycle produce one pulse and one increment.
- Reset:
  - reset high at an edge forces reset values at that edge, aborting any in-progress debounce or prescale count.
  - No ce pulse is emitted in the cycle after reset is released.
  - After reset is released, a button already held high is treated as a new press and needs the full debounce.
- Changing auto_en from 1 to 0 in the cycle a wrap would occur suppresses that auto step.

## Test plan
Bench overrides: DEBOUNCE_CYCLES=4, AUTO_DIV=8.

- Clean press: target_sel=00, btn_raw high from edge 10 held 20 cycles, then low → ce_d high for exactly edge 16–17 only; step_count=1; ce_jk=ce_t=0 throughout.
- Bounce reject: btn_raw pattern 1,1,0,1,1,0 then low for 10 cycles → no ce pulses; step_count=0; dbg_state returns to 0.
- Round-robin: target_sel=11, four clean presses → ce_d, ce_jk, ce_t, ce_d in that order; step_count=4.
- Auto mode with wrap: target_sel=10, auto_en=1 for 8×260 cycles → ce_t pulses every 8 cycles; step_count passes 255→0 and ends at 4.
- Coincidence: a button step aligned with the auto step cycle → exactly one ce pulse; step_count advances by 1.
- Mid-operation reset: reset asserted while in PRESS_WAIT with count=3, btn_raw still high → no pulse; dbg_state=0 during reset; after release the next pulse occurs DEBOUNCE_CYCLES+2 edges after the first post-reset sample.
